// File: rtl/gemm_pkg.sv
// Shared constants, FSM state type and tile-element helpers for the int8 GeMM tile engine.
package gemm_pkg;

   localparam int unsigned InDataWidth  = 8;
   localparam int unsigned OutDataWidth = 32;
   localparam int unsigned TileM        = 4;
   localparam int unsigned TileN        = 4;
   localparam int unsigned TileK        = 4;

   localparam int unsigned TileAWidth = InDataWidth * TileM * TileK;
   localparam int unsigned TileBWidth = InDataWidth * TileK * TileN;
   localparam int unsigned TileCWidth = OutDataWidth * TileM * TileN;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDrain,
      StWrite,
      StDone
   } state_e;

   function automatic logic signed [InDataWidth-1:0] a_elem(input logic [TileAWidth-1:0] tile,
                                                            input int unsigned i,
                                                            input int unsigned k);
      return tile[(i*TileK+k)*InDataWidth +: InDataWidth];
   endfunction

   function automatic logic signed [InDataWidth-1:0] b_elem(input logic [TileBWidth-1:0] tile,
                                                            input int unsigned k,
                                                            input int unsigned j);
      return tile[(k*TileN+j)*InDataWidth +: InDataWidth];
   endfunction

   // Full-precision product, sign-extended to accumulator width.
   function automatic logic [OutDataWidth-1:0] mul_ext(input logic signed [InDataWidth-1:0] a,
                                                       input logic signed [InDataWidth-1:0] b);
      logic signed [2*InDataWidth-1:0] p;
      p = a * b;
      return {{(OutDataWidth-2*InDataWidth){p[2*InDataWidth-1]}}, p};
   endfunction

endpackage

// File: rtl/gemm_tile_mac.sv
// 4x4x4 signed MAC array feeding 16 registered accumulators with load/accumulate control.
module gemm_tile_mac
   import gemm_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  load_i,
   input  logic [TileAWidth-1:0] a_tile_i,
   input  logic [TileBWidth-1:0] b_tile_i,
   output logic [TileCWidth-1:0] acc_o
);

   logic [TileCWidth-1:0]   acc_q;
   logic [TileCWidth-1:0]   acc_d;
   logic [OutDataWidth-1:0] dot;

   always_comb begin
      acc_d = acc_q;
      dot   = '0;
      for (int unsigned i = 0; i < TileM; i++) begin
         for (int unsigned j = 0; j < TileN; j++) begin
            dot = '0;
            for (int unsigned k = 0; k < TileK; k++) begin
               dot = dot + mul_ext(a_elem(a_tile_i, i, k), b_elem(b_tile_i, k, j));
            end
            // Load on the first kt of a tile so nothing carries over from the previous tile.
            if (load_i) begin
               acc_d[(i*TileN+j)*OutDataWidth +: OutDataWidth] = dot;
            end else begin
               acc_d[(i*TileN+j)*OutDataWidth +: OutDataWidth] =
                  acc_q[(i*TileN+j)*OutDataWidth +: OutDataWidth] + dot;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/gemm_tile_accelerator.sv
// Tiled signed int8 GeMM: FSM, tile counters and SRAM address generation around the MAC array.
module gemm_tile_accelerator #(
   parameter int unsigned InDataWidth   = 8,
   parameter int unsigned OutDataWidth  = 32,
   parameter int unsigned AddrWidth     = 6,
   parameter int unsigned SizeAddrWidth = 8,
   parameter int unsigned M             = 4,
   parameter int unsigned N             = 4,
   parameter int unsigned K             = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic [SizeAddrWidth-1:0]       M_size_i,
   input  logic [SizeAddrWidth-1:0]       K_size_i,
   input  logic [SizeAddrWidth-1:0]       N_size_i,
   output logic [AddrWidth-1:0]           sram_a_addr_o,
   output logic [AddrWidth-1:0]           sram_b_addr_o,
   output logic [AddrWidth-1:0]           sram_c_addr_o,
   input  logic [InDataWidth*M*K-1:0]     sram_a_rdata_i,
   input  logic [InDataWidth*K*N-1:0]     sram_b_rdata_i,
   output logic [OutDataWidth*M*N-1:0]    sram_c_wdata_o,
   output logic                           sram_c_we_o,
   output logic                           done_o
);

   import gemm_pkg::*;

   state_e                   state_q;
   logic [SizeAddrWidth-1:0] m_tiles_q, k_tiles_q, n_tiles_q;
   logic [SizeAddrWidth-1:0] mt_cnt_q, kt_cnt_q, nt_cnt_q;
   logic [AddrWidth-1:0]     a_addr_q, b_addr_q, c_addr_q, a_base_q;
   logic                     we_q, done_q;
   logic                     rd_valid_q, rd_first_q;
   logic [SizeAddrWidth-1:0] m_tiles_in, k_tiles_in, n_tiles_in;
   logic [OutDataWidth*M*N-1:0] acc;

   assign m_tiles_in = M_size_i / SizeAddrWidth'(M);
   assign k_tiles_in = K_size_i / SizeAddrWidth'(K);
   assign n_tiles_in = N_size_i / SizeAddrWidth'(N);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         m_tiles_q  <= '0;
         k_tiles_q  <= '0;
         n_tiles_q  <= '0;
         mt_cnt_q   <= '0;
         kt_cnt_q   <= '0;
         nt_cnt_q   <= '0;
         a_addr_q   <= '0;
         b_addr_q   <= '0;
         c_addr_q   <= '0;
         a_base_q   <= '0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_first_q <= 1'b0;
      end else begin
         // Read data returns one cycle after the address, so tag it with the issuing kt.
         rd_valid_q <= (state_q == StFetch);
         rd_first_q <= (state_q == StFetch) && (kt_cnt_q == '0);
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  m_tiles_q <= m_tiles_in;
                  k_tiles_q <= k_tiles_in;
                  n_tiles_q <= n_tiles_in;
                  mt_cnt_q  <= '0;
                  kt_cnt_q  <= '0;
                  nt_cnt_q  <= '0;
                  a_addr_q  <= '0;
                  b_addr_q  <= '0;
                  c_addr_q  <= '0;
                  a_base_q  <= '0;
                  if ((m_tiles_in == '0) || (k_tiles_in == '0) || (n_tiles_in == '0)) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StFetch;
                  end
               end
            end
            StFetch: begin
               if (kt_cnt_q == k_tiles_q - 1'b1) begin
                  state_q <= StDrain;
               end else begin
                  kt_cnt_q <= kt_cnt_q + 1'b1;
                  a_addr_q <= a_addr_q + 1'b1;
                  b_addr_q <= b_addr_q + AddrWidth'(n_tiles_q);
               end
            end
            StDrain: begin
               state_q <= StWrite;
               we_q    <= 1'b1;
            end
            StWrite: begin
               // C words are visited in row-major tile order, so the C address just increments.
               c_addr_q <= c_addr_q + 1'b1;
               kt_cnt_q <= '0;
               if (nt_cnt_q != n_tiles_q - 1'b1) begin
                  nt_cnt_q <= nt_cnt_q + 1'b1;
                  a_addr_q <= a_base_q;
                  b_addr_q <= AddrWidth'(nt_cnt_q + 1'b1);
                  state_q  <= StFetch;
               end else if (mt_cnt_q != m_tiles_q - 1'b1) begin
                  nt_cnt_q <= '0;
                  mt_cnt_q <= mt_cnt_q + 1'b1;
                  a_base_q <= a_base_q + AddrWidth'(k_tiles_q);
                  a_addr_q <= a_base_q + AddrWidth'(k_tiles_q);
                  b_addr_q <= '0;
                  state_q  <= StFetch;
               end else begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   gemm_tile_mac u_mac (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (rd_valid_q),
      .load_i   (rd_first_q),
      .a_tile_i (sram_a_rdata_i),
      .b_tile_i (sram_b_rdata_i),
      .acc_o    (acc)
   );

   assign sram_a_addr_o  = a_addr_q;
   assign sram_b_addr_o  = b_addr_q;
   assign sram_c_addr_o  = c_addr_q;
   assign sram_c_we_o    = we_q;
   assign sram_c_wdata_o = we_q ? acc : '0;
   assign done_o         = done_q;

endmodule

// File: tb/tb_gemm_tile_accelerator.sv
// Directed bench for gemm_tile_accelerator with behavioural A/B/C SRAMs and a golden int32 GeMM.
module tb_gemm_tile_accelerator;

   localparam int Budget = 2000;
   localparam int WrMax  = 512;
   localparam int PId = 0, PSeq = 1, PNeg = 2, POne = 3, PRnd = 4;

   typedef struct {
      int m, k, n;
      int pa, pb;
      int exp_lat;
      int exp_writes;
      bit hand;
      int exp_c00;
      int exp_c33;
   } vec_t;

   logic         clk, rst_n, start;
   logic [7:0]   m_size, k_size, n_size;
   logic [5:0]   a_addr, b_addr, c_addr;
   logic [127:0] a_rdata, b_rdata;
   logic [511:0] c_wdata;
   logic         c_we, done;

   logic [127:0] mem_a [64];
   logic [127:0] mem_b [64];
   logic [511:0] wr_data [WrMax];
   int           wr_addr [WrMax];
   int           wr_cnt = 0;
   int           done_cnt = 0;
   int           rec_a [Budget];
   int           rec_b [Budget];
   int           checks = 0;
   int           errors = 0;
   vec_t         vecs [7];

   gemm_tile_accelerator dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .start_i        (start),
      .M_size_i       (m_size),
      .K_size_i       (k_size),
      .N_size_i       (n_size),
      .sram_a_addr_o  (a_addr),
      .sram_b_addr_o  (b_addr),
      .sram_c_addr_o  (c_addr),
      .sram_a_rdata_i (a_rdata),
      .sram_b_rdata_i (b_rdata),
      .sram_c_wdata_o (c_wdata),
      .sram_c_we_o    (c_we),
      .done_o         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous SRAMs and write/done logging.
   always @(posedge clk) begin
      a_rdata <= mem_a[a_addr];
      b_rdata <= mem_b[b_addr];
      if (c_we) begin
         if (wr_cnt < WrMax) begin
            wr_addr[wr_cnt] = int'(c_addr);
            wr_data[wr_cnt] = c_wdata;
         end
         wr_cnt = wr_cnt + 1;
      end
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [127:0] pat_word(input int p);
      logic [127:0] w;
      int           v;
      w = '0;
      for (int idx = 0; idx < 16; idx++) begin
         case (p)
            PId:     v = ((idx / 4) == (idx % 4)) ? 1 : 0;
            PSeq:    v = idx + 1;
            PNeg:    v = -128;
            POne:    v = 1;
            default: v = int'($urandom_range(0, 255));
         endcase
         w[idx*8 +: 8] = 8'(v);
      end
      return w;
   endfunction

   function automatic int gold(input int i, input int j, input int kt_n, input int nt_n);
      int               s;
      logic signed [7:0] ae, be;
      s = 0;
      for (int kk = 0; kk < kt_n * 4; kk++) begin
         ae = mem_a[(i/4)*kt_n + kk/4][((i%4)*4 + kk%4)*8 +: 8];
         be = mem_b[(kk/4)*nt_n + j/4][((kk%4)*4 + j%4)*8 +: 8];
         s  = s + int'(ae) * int'(be);
      end
      return s;
   endfunction

   task automatic run(input vec_t v, input bit poke);
      int mt_n, kt_n, nt_n, tiles, n, w0, d0, bad, mt, nt, idx, got;
      mt_n = v.m / 4;
      kt_n = v.k / 4;
      nt_n = v.n / 4;
      tiles = mt_n * nt_n;
      for (int w = 0; w < 64; w++) begin
         mem_a[w] = pat_word(v.pa);
         mem_b[w] = pat_word(v.pb);
      end
      m_size = 8'(v.m);
      k_size = 8'(v.k);
      n_size = 8'(v.n);
      w0 = wr_cnt;
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (!done && n < Budget) begin
         rec_a[n] = int'(a_addr);
         rec_b[n] = int'(b_addr);
         if (poke && n == 3) begin
            start  = 1'b1;
            m_size = 8'd4;
            k_size = 8'd4;
            n_size = 8'd4;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("latency", n, v.exp_lat);
      repeat (3) @(negedge clk);
      check("done_once", done_cnt - d0, 1);
      check("writes", wr_cnt - w0, v.exp_writes);

      bad = 0;
      for (int t = 0; t < tiles; t++) begin
         if (w0 + t < WrMax && wr_addr[w0 + t] != t) bad++;
      end
      check("wr_order", bad, 0);

      bad = 0;
      for (int t = 0; t < tiles; t++) begin
         mt = t / nt_n;
         nt = t % nt_n;
         for (int ii = 0; ii < 4; ii++) begin
            for (int jj = 0; jj < 4; jj++) begin
               got = int'(wr_data[w0 + t][(ii*4 + jj)*32 +: 32]);
               if (got != gold(mt*4 + ii, nt*4 + jj, kt_n, nt_n)) bad++;
            end
         end
      end
      check("tile_data", bad, 0);

      bad = 0;
      for (int t = 0; t < tiles; t++) begin
         mt = t / nt_n;
         nt = t % nt_n;
         for (int kt = 0; kt < kt_n; kt++) begin
            idx = t * (kt_n + 2) + kt;
            if (idx < Budget) begin
               if (rec_a[idx] != ((mt*kt_n + kt) % 64)) bad++;
               if (rec_b[idx] != ((kt*nt_n + nt) % 64)) bad++;
            end
         end
      end
      check("addr_seq", bad, 0);

      if (v.hand && tiles > 0) begin
         check("c00", int'(wr_data[w0][31:0]), v.exp_c00);
         check("c33", int'(wr_data[w0][15*32 +: 32]), v.exp_c33);
      end
   endtask

   initial begin
      int ea [6];
      int eb [6];
      int ix [6];
      int w0, d0;
      ea = '{0, 1, 2, 3, 4, 5};
      eb = '{0, 1, 2, 0, 1, 2};
      ix = '{0, 1, 2, 5, 6, 7};

      vecs[0] = '{4, 4, 4, PId, PSeq, 3, 1, 1'b1, 1, 16};
      vecs[1] = '{4, 4, 4, PNeg, PNeg, 3, 1, 1'b1, 65536, 65536};
      vecs[2] = '{8, 12, 4, POne, POne, 10, 2, 1'b1, 12, 12};
      vecs[3] = '{32, 32, 32, PRnd, PRnd, 640, 64, 1'b0, 0, 0};
      vecs[4] = '{0, 4, 4, POne, POne, 0, 0, 1'b0, 0, 0};
      vecs[5] = '{7, 4, 5, POne, POne, 3, 1, 1'b1, 4, 4};
      vecs[6] = '{4, 4, 3, POne, POne, 0, 0, 1'b0, 0, 0};

      rst_n  = 1'b0;
      start  = 1'b0;
      m_size = '0;
      k_size = '0;
      n_size = '0;
      for (int w = 0; w < 64; w++) begin
         mem_a[w] = '0;
         mem_b[w] = '0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_state", {a_addr, b_addr, c_addr, c_we, done, |c_wdata}, 0);

      for (int i = 0; i < 7; i++) begin
         run(vecs[i], 1'b0);
         if (i == 2) begin
            for (int p = 0; p < 6; p++) begin
               check("ab_addr_8x12x4", {rec_a[ix[p]], rec_b[ix[p]]}, {ea[p], eb[p]});
            end
         end
      end

      // Start pulse and new sizes during a run must not disturb it.
      run(vecs[2], 1'b1);

      // Asynchronous reset in the middle of FETCH.
      for (int w = 0; w < 64; w++) begin
         mem_a[w] = pat_word(PRnd);
         mem_b[w] = pat_word(PRnd);
      end
      m_size = 8'd32;
      k_size = 8'd32;
      n_size = 8'd32;
      w0 = wr_cnt;
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_reset_a_addr", a_addr, 4);
      #2 rst_n = 1'b0;
      #1 check("rst_async", {a_addr, b_addr, c_addr, c_we, done, |c_wdata}, 0);
      repeat (3) @(negedge clk);
      check("rst_no_write", wr_cnt - w0, 0);
      check("rst_no_done", done_cnt - d0, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run(vecs[0], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
